// File: rtl/sumador_pkg.sv
// Shared types and default sizing for the sequential chunked adder.
package sumador_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sumador_chunk.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
module sumador_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};

endmodule

// File: rtl/sumador_secuencial.sv
// Sequential adder: one CHUNK-bit slice per clock, LSB slice first.
// Optional subtract mode is enabled by defining SUMADOR_SUB_EN.
module sumador_secuencial
  import sumador_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic             cout
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("sumador_secuencial: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
  end

  logic sub_eff;
`ifdef SUMADOR_SUB_EN
  assign sub_eff = sub;
`else
  // Masked to a constant so the inversion and carry preset fold away.
  assign sub_eff = sub & 1'b0;
`endif

  state_t             state_q;
  logic [WIDTH-1:0]   a_q, b_q, acc_q, acc_d;
  logic [WIDTH:0]     sum_q;
  logic [IDXW-1:0]    idx_q;
  logic               carry_q, busy_q, done_q;
  logic [CHUNK-1:0]   slice_a, slice_b, slice_sum;
  logic               slice_cout;

  assign slice_a = a_q[idx_q*CHUNK +: CHUNK];
  assign slice_b = b_q[idx_q*CHUNK +: CHUNK];

  sumador_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Partial result accumulates privately; sum only updates on completion.
  always_comb begin
    acc_d = acc_q;
    acc_d[idx_q*CHUNK +: CHUNK] = slice_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub_eff ? ~b : b;
            carry_q <= sub_eff;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          carry_q <= slice_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            sum_q   <= {slice_cout, acc_d};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = sum_q[WIDTH];

endmodule

// File: tb/tb_sumador_secuencial.sv
// Self-checking bench for sumador_secuencial (8x4 and 8x1 instances); honours SUMADOR_SUB_EN.
module tb_sumador_secuencial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, sub0 = 1'b0, start1 = 1'b0, sub1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       busy0, done0, cout0, busy1, done1, cout1;
  logic [8:0] sum0, sum1;
  logic [8:0] last0 = '0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  sumador_secuencial #(.WIDTH(8), .CHUNK(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .sub(sub0),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0)
  );

  sumador_secuencial #(.WIDTH(8), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .sub(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // Reference: plain unsigned arithmetic on 9 bits.
  function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv, input logic s);
`ifdef SUMADOR_SUB_EN
    if (s) return {1'b0, av} + {1'b0, ~bv} + 9'd1;
`endif
    return {1'b0, av} + {1'b0, bv};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One operation on the 8x4 instance; repulse drives new operands during RUN and start in DONE.
  task automatic op0(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic s, input bit repulse);
    logic [8:0] exp;
    int lat, nbusy, ndone;
    bit seen;
    exp = model(av, bv, s);
    a0 = av; b0 = bv; sub0 = s; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check({tag, "_busy_start"}, busy0, 1);
    lat = 0; nbusy = 1; seen = 0;
    while (!seen && lat < 20) begin
      if (repulse && lat == 0) begin
        start0 = 1'b1; a0 = ~av; b0 = 8'h33; sub0 = ~s;
      end else begin
        start0 = 1'b0;
      end
      tick();
      lat++;
      if (busy0 && done0) check({tag, "_busy_and_done"}, 1, 0);
      if (busy0) nbusy++;
      if (done0) seen = 1;
      else check({tag, "_sum_hold"}, sum0, last0);
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_busy_cycles"}, nbusy, 2);
    check({tag, "_sum"}, sum0, exp);
    check({tag, "_cout"}, cout0, exp[8]);
    if (repulse) start0 = 1'b1;
    tick();
    start0 = 1'b0;
    ndone = done0;
    check({tag, "_done_one_pulse"}, ndone, 0);
    if (repulse) check({tag, "_done_start_ignored"}, busy0, 0);
    check({tag, "_sum_after"}, sum0, exp);
    $display("op %s: a=%0d b=%0d sub=%0d -> sum=%0h exp=%0h lat=%0d", tag, av, bv, s, sum0, exp, lat);
    last0 = exp;
    tick();
  endtask

  initial begin
    int lat, nbusy, gap;
    logic [7:0] ra, rb;
    logic rs;

    tick(); tick();
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_sum0", sum0, 0);
    check("rst_cout0", cout0, 0);
    check("rst_busy1", busy1, 0);
    check("rst_sum1", sum1, 0);
    rst = 1'b0;
    tick();

    op0("15p12", 8'd15, 8'd12, 1'b0, 0);
    op0("255p255", 8'd255, 8'd255, 1'b0, 0);
    op0("5p5", 8'd5, 8'd5, 1'b0, 0);
    op0("5m5", 8'd5, 8'd5, 1'b1, 0);
    op0("6m13", 8'd6, 8'd13, 1'b1, 0);
    op0("repulse", 8'd100, 8'd77, 1'b0, 1);

    // Reset in the second RUN cycle aborts the operation.
    a0 = 8'd200; b0 = 8'd100; sub0 = 1'b0; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy0, 0);
    check("abort_sum", sum0, 0);
    check("abort_done", done0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done0) check("abort_no_done", done0, 0);
    end
    last0 = '0;
    op0("post_rst_6p13", 8'd6, 8'd13, 1'b0, 0);

    // Reset wins over start in the same cycle.
    rst = 1'b1; start0 = 1'b1; a0 = 8'd1; b0 = 8'd2;
    tick();
    rst = 1'b0; start0 = 1'b0;
    check("rst_prio_busy", busy0, 0);
    check("rst_prio_sum", sum0, 0);
    last0 = '0;
    tick();

    // Start held high: consecutive operations every N+2 edges.
    a0 = 8'd40; b0 = 8'd2; sub0 = 1'b0; start0 = 1'b1;
    tick();
    lat = 0;
    while (!done0 && lat < 20) begin tick(); lat++; end
    check("b2b_done_seen", done0, 1);
    check("b2b_sum", sum0, 9'd42);
    gap = 0;
    do begin tick(); gap++; end while (!busy0 && gap < 10);
    check("b2b_restart_gap", gap, 2);
    start0 = 1'b0;
    lat = 0;
    while (!done0 && lat < 20) begin tick(); lat++; end
    check("b2b_second_sum", sum0, 9'd42);
    $display("op b2b: 40+2 restart gap=%0d sum=%0h", gap, sum0);
    last0 = 9'd42;
    tick(); tick();

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      op0($sformatf("rnd%0d", i), ra, rb, rs, 1'($urandom_range(0, 1)));
    end

    // CHUNK=1 instance: 8 busy cycles, done one edge later.
    a1 = 8'd255; b1 = 8'd1; sub1 = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 0; nbusy = busy1 ? 1 : 0;
    while (!done1 && lat < 30) begin
      tick(); lat++;
      if (busy1) nbusy++;
    end
    check("c1_latency", lat, 8);
    check("c1_busy_cycles", nbusy, 8);
    check("c1_sum", sum1, 9'h100);
    check("c1_cout", cout1, 1);
    $display("op c1_255p1: sum=%0h lat=%0d busy=%0d", sum1, lat, nbusy);
    tick();
    check("c1_done_one_pulse", done1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
